// File: rtl/cronometro_mmss_if.sv
// Control and status bundle for the MM:SS stopwatch.
// The stopwatch core connects through the slave modport.
// The board top level or a bench connects through the master modport.
interface cronometro_mmss_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] sec_u;
  logic [2:0] sec_t;
  logic [3:0] min_u;
  logic [2:0] min_t;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dg;
  logic       running;
  logic       ovf;
  logic       lap_held;

  modport master (
    output start_stop, clear, lap,
    input  sec_u, sec_t, min_u, min_t, seg, dp, dg, running, ovf, lap_held
  );

  modport slave (
    input  start_stop, clear, lap,
    output sec_u, sec_t, min_u, min_t, seg, dp, dg, running, ovf, lap_held
  );
endinterface

// File: rtl/cronometro_mmss.sv
// MM:SS stopwatch with a start/pause/clear FSM and a prescaled count tick.
// It has cascaded BCD counters (00:00..59:59) with a sticky overflow flag.
// It drives a multiplexed 4-digit 7-segment display.
// The optional lap-hold display freeze is enabled by defining CRONOMETRO_LAP_EN.
module cronometro_mmss #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter bit DG_ACT_LO = 1'b1
) (
  input logic              i_clk_in,
  input logic              i_rst,
  cronometro_mmss_if.slave io_bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_ss_cur, r_ss_prev, r_cl_cur, r_cl_prev;
  logic          w_ss_edge, w_cl_edge, w_run, w_clr, w_active, w_tick;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_sec_u, r_min_u;
  logic [2:0]    r_sec_t, r_min_t;
  logic          r_ovf, r_running;
  logic [SW-1:0] r_scan_cnt;
  logic [1:0]    r_scan_idx;
  logic [13:0]   w_live, w_disp;
  logic          w_lap_held;
  logic [3:0]    w_digit, w_dg_sel;
  logic [3:0]    r_dg;
  logic [6:0]    r_seg;
  logic          r_dp;

  // Active-high {a..g} pattern for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // sample start/stop and clear once; keep the previous sample for rising-edge detection
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_ss_cur  <= 1'b0;
      r_ss_prev <= 1'b0;
      r_cl_cur  <= 1'b0;
      r_cl_prev <= 1'b0;
    end else begin
      r_ss_cur  <= io_bus.start_stop;
      r_ss_prev <= r_ss_cur;
      r_cl_cur  <= io_bus.clear;
      r_cl_prev <= r_cl_cur;
    end
  end

  assign w_ss_edge = r_ss_cur & ~r_ss_prev;
  assign w_cl_edge = r_cl_cur & ~r_cl_prev;

  // FSM state register
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state: SS wins over CLEAR in RUN; CLEAR wins over SS when stopped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cl_edge)      w_state_nxt = ST_IDLE;
        else if (w_ss_edge) w_state_nxt = ST_RUN;
        else                w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_ss_edge) w_state_nxt = ST_PAUSE;
        else           w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_cl_edge)      w_state_nxt = ST_IDLE;
        else if (w_ss_edge) w_state_nxt = ST_RUN;
        else                w_state_nxt = ST_PAUSE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: counting enable, effective clear and "not idle" qualifier
  always_comb begin
    w_run    = 1'b0;
    w_clr    = 1'b0;
    w_active = 1'b0;
    case (r_state)
      ST_IDLE:  w_clr = w_cl_edge;
      ST_RUN: begin
        w_run    = 1'b1;
        w_active = 1'b1;
      end
      ST_PAUSE: begin
        w_clr    = w_cl_edge;
        w_active = 1'b1;
      end
      default: w_clr = 1'b0;
    endcase
  end

  assign w_tick = w_run & (r_presc == P_MAX);

  // RUNNING flag registered from the next state so it tracks the state register
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_running <= 1'b0;
    end else begin
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  // prescaler: advances only in RUN, holds in PAUSE so sub-second progress survives
  always_ff @(posedge i_clk_in) begin
    if (i_rst || w_clr) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else if (w_run) begin
      r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      r_presc <= r_presc;
    end
  end

  // cascaded BCD counters; the wrap past 59:59 sets the sticky overflow flag
  always_ff @(posedge i_clk_in) begin
    if (i_rst || w_clr) begin
      r_sec_u <= 4'd0;
      r_sec_t <= 3'd0;
      r_min_u <= 4'd0;
      r_min_t <= 3'd0;
      r_ovf   <= 1'b0;
    end else if (w_tick) begin
      if (r_sec_u != 4'd9) begin
        r_sec_u <= r_sec_u + 4'd1;
      end else begin
        r_sec_u <= 4'd0;
        if (r_sec_t != 3'd5) begin
          r_sec_t <= r_sec_t + 3'd1;
        end else begin
          r_sec_t <= 3'd0;
          if (r_min_u != 4'd9) begin
            r_min_u <= r_min_u + 4'd1;
          end else begin
            r_min_u <= 4'd0;
            if (r_min_t != 3'd5) begin
              r_min_t <= r_min_t + 3'd1;
            end else begin
              r_min_t <= 3'd0;
              r_ovf   <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_live = {r_min_t, r_min_u, r_sec_t, r_sec_u};

`ifdef CRONOMETRO_LAP_EN
  logic        r_lap_cur, r_lap_prev, r_lap_held;
  logic [13:0] r_snap;
  logic        w_lap_edge;

  assign w_lap_edge = r_lap_cur & ~r_lap_prev;

  // lap hold: toggle on LAP edge outside IDLE; capture the live count when entering hold
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_lap_cur  <= 1'b0;
      r_lap_prev <= 1'b0;
      r_lap_held <= 1'b0;
      r_snap     <= 14'd0;
    end else begin
      r_lap_cur  <= io_bus.lap;
      r_lap_prev <= r_lap_cur;
      if (w_clr) begin
        r_lap_held <= 1'b0;
      end else if (w_lap_edge && w_active) begin
        r_lap_held <= ~r_lap_held;
        if (!r_lap_held) begin
          r_snap <= w_live;
        end
      end
    end
  end

  assign w_lap_held = r_lap_held;
  assign w_disp     = r_lap_held ? r_snap : w_live;
`else
  assign w_lap_held = 1'b0;
  assign w_disp     = w_live;
`endif

  // free-running scan divider and digit index
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
    end else if (r_scan_cnt == S_MAX) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + {{(SW-1){1'b0}}, 1'b1};
      r_scan_idx <= r_scan_idx;
    end
  end

  // select the digit value and one-hot enable for the current scan index
  always_comb begin
    w_digit  = 4'd0;
    w_dg_sel = 4'b0001;
    case (r_scan_idx)
      2'd0: begin w_digit = w_disp[3:0];           w_dg_sel = 4'b0001; end
      2'd1: begin w_digit = {1'b0, w_disp[6:4]};   w_dg_sel = 4'b0010; end
      2'd2: begin w_digit = w_disp[10:7];          w_dg_sel = 4'b0100; end
      2'd3: begin w_digit = {1'b0, w_disp[13:11]}; w_dg_sel = 4'b1000; end
      default: begin w_digit = 4'd0;               w_dg_sel = 4'b0001; end
    endcase
  end

  // DG, SEG and DP registered together so the pattern always matches the enabled digit
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_dg  <= DG_ACT_LO ? 4'b1110 : 4'b0001;
      r_seg <= 7'b1111110;
      r_dp  <= 1'b0;
    end else begin
      r_dg  <= DG_ACT_LO ? ~w_dg_sel : w_dg_sel;
      r_seg <= seg_decode(w_digit);
      r_dp  <= (r_scan_idx == 2'd2) & w_active;
    end
  end

  assign io_bus.sec_u    = r_sec_u;
  assign io_bus.sec_t    = r_sec_t;
  assign io_bus.min_u    = r_min_u;
  assign io_bus.min_t    = r_min_t;
  assign io_bus.seg      = r_seg;
  assign io_bus.dp       = r_dp;
  assign io_bus.dg       = r_dg;
  assign io_bus.running  = r_running;
  assign io_bus.ovf      = r_ovf;
  assign io_bus.lap_held = w_lap_held;
endmodule

// File: tb/tb_cronometro_mmss.sv
// Self-checking bench for cronometro_mmss (TICK_DIV=4, SCAN_DIV=2, active-low digits).
// A behavioural model tracks elapsed time as a plain seconds count.
// Define CRONOMETRO_LAP_EN for both RTL and bench to exercise lap hold.
module tb_cronometro_mmss;
  localparam int TD = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cronometro_mmss_if bus ();

  cronometro_mmss #(.TICK_DIV(TD), .SCAN_DIV(SD), .DG_ACT_LO(1'b1)) dut (
    .i_clk_in(clk),
    .i_rst   (rst),
    .io_bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 idle, 1 run, 2 pause; time kept as total seconds
  int m_state = 0, m_presc = 0, m_secs = 0, m_snap = 0, m_disp_q = 0;
  bit m_ovf = 1'b0, m_held = 1'b0, m_dp_q = 1'b0;
  bit m_ss_c = 1'b0, m_ss_p = 1'b0, m_cl_c = 1'b0, m_cl_p = 1'b0, m_lp_c = 1'b0, m_lp_p = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  function automatic int digit_of(input int s, input int k);
    int mm = s / 60;
    int ss = s % 60;
    case (k)
      0: return ss % 10;
      1: return ss / 10;
      2: return mm % 10;
      default: return mm / 10;
    endcase
  endfunction

  function automatic logic [13:0] pack(input int s);
    logic [13:0] r;
    r[3:0]   = 4'(digit_of(s, 0));
    r[6:4]   = 3'(digit_of(s, 1));
    r[10:7]  = 4'(digit_of(s, 2));
    r[13:11] = 3'(digit_of(s, 3));
    return r;
  endfunction

  function automatic logic [13:0] dut_count();
    return {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  endfunction

  task automatic model_step();
    bit ss_e, cl_e, lp_e, tick, clr;
    int nst;
    if (rst) begin
      m_state = 0; m_presc = 0; m_secs = 0; m_snap = 0; m_ovf = 1'b0; m_held = 1'b0;
      m_disp_q = 0; m_dp_q = 1'b0;
      m_ss_c = 1'b0; m_ss_p = 1'b0; m_cl_c = 1'b0; m_cl_p = 1'b0; m_lp_c = 1'b0; m_lp_p = 1'b0;
    end else begin
      m_disp_q = m_held ? m_snap : m_secs;
      m_dp_q   = (m_state != 0);
      ss_e = m_ss_c & !m_ss_p;
      cl_e = m_cl_c & !m_cl_p;
      lp_e = m_lp_c & !m_lp_p;
      tick = (m_state == 1) && (m_presc == TD - 1);
      clr  = (m_state != 1) && cl_e;
      nst  = m_state;
      if (m_state == 1) begin
        if (ss_e) nst = 2;
      end else if (cl_e) begin
        nst = 0;
      end else if (ss_e) begin
        nst = 1;
      end
      if (clr) begin
        m_presc = 0; m_secs = 0; m_ovf = 1'b0; m_held = 1'b0;
      end else begin
`ifdef CRONOMETRO_LAP_EN
        if (lp_e && m_state != 0) begin
          if (!m_held) m_snap = m_secs;
          m_held = !m_held;
        end
`endif
        if (m_state == 1) m_presc = tick ? 0 : m_presc + 1;
        if (tick) begin
          m_secs = m_secs + 1;
          if (m_secs == 3600) begin
            m_secs = 0;
            m_ovf  = 1'b1;
          end
        end
      end
      m_state = nst;
      m_ss_p = m_ss_c; m_ss_c = bus.start_stop;
      m_cl_p = m_cl_c; m_cl_c = bus.clear;
      m_lp_p = m_lp_c; m_lp_c = bus.lap;
    end
  endtask

  task automatic check_outputs();
    int k;
    check_eq("count", dut_count(), pack(m_secs));
    check_eq("running", bus.running, m_state == 1);
    check_eq("ovf", bus.ovf, m_ovf);
    check_eq("lap_held", bus.lap_held, m_held);
    case (bus.dg)
      4'b1110: k = 0;
      4'b1101: k = 1;
      4'b1011: k = 2;
      4'b0111: k = 3;
      default: k = -1;
    endcase
    check_eq("dg_onehot", k >= 0, 1'b1);
    if (k >= 0) begin
      check_eq("seg_vs_dg", bus.seg, seg_of(digit_of(m_disp_q, k)));
      check_eq("dp_vs_dg", bus.dp, (k == 2) && m_dp_q);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse(input bit ss, input bit cl, input bit lp);
    bus.start_stop = ss; bus.clear = cl; bus.lap = lp;
    cyc();
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (m_secs != target && n < budget) begin
      cyc();
      n++;
    end
    check_eq(tag, m_secs == target, 1'b1);
  endtask

  task automatic wait_dg(input logic [3:0] v, input bit eq, input string tag);
    int n = 0;
    while (((bus.dg == v) != eq) && n < 20) begin
      cyc();
      n++;
    end
    check_eq(tag, (bus.dg == v) == eq, 1'b1);
  endtask

  task automatic check_display(input int v, input string tag);
    wait_dg(4'b1110, 1'b0, "align_off");
    wait_dg(4'b1110, 1'b1, "align_on");
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        check_eq(tag, bus.seg, seg_of(digit_of(v, k)));
        cyc();
      end
    end
  endtask

  logic [3:0] dg_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_exp [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};

  initial begin
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    check_eq("rst_count", dut_count(), 14'd0);
    check_eq("rst_dg", bus.dg, 4'b1110);
    check_eq("rst_seg", bus.seg, 7'b1111110);
    check_eq("rst_dp", bus.dp, 1'b0);
    check_eq("rst_running", bus.running, 1'b0);
    check_eq("rst_ovf", bus.ovf, 1'b0);
    check_eq("rst_lap_held", bus.lap_held, 1'b0);
    rst = 1'b0;
    cyc();

    // count: 240 cycles in RUN is one minute
    bus.start_stop = 1'b1; cyc();
    bus.start_stop = 1'b0; cyc();
    repeat (240) cyc();
    check_eq("count_1min", dut_count(), 14'b000_0001_000_0000);
    check_eq("count_running", bus.running, 1'b1);
    check_eq("count_ovf", bus.ovf, 1'b0);

    // pause two cycles into a tick period, hold, then resume
    begin
      int s0, n;
      n = 0;
      while (m_presc != 0 && n < 10) begin cyc(); n++; end
      pulse(1'b1, 1'b0, 1'b0);
      s0 = m_secs;
      repeat (100) cyc();
      check_eq("pause_hold", dut_count(), pack(s0));
      check_eq("pause_running", bus.running, 1'b0);
      bus.start_stop = 1'b1; cyc();
      bus.start_stop = 1'b0; cyc();
      check_eq("resume_running", bus.running, 1'b1);
      cyc();
      check_eq("resume_1cyc", dut_count(), pack(s0));
      cyc();
      check_eq("resume_2cyc", dut_count(), pack(s0 + 1));
    end

    // overflow at 59:59, then pause and clear
    run_until(3599, 16000, "to_5959");
    run_until(0, 10, "to_wrap");
    check_eq("ovf_count", dut_count(), 14'd0);
    check_eq("ovf_set", bus.ovf, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("ovf_kept_pause", bus.ovf, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("clr_ovf", bus.ovf, 1'b0);
    check_eq("clr_count", dut_count(), 14'd0);
    check_eq("clr_running", bus.running, 1'b0);

    // simultaneous SS and CLEAR edges
    pulse(1'b1, 1'b0, 1'b0);
    run_until(7, 100, "to_0007");
    pulse(1'b1, 1'b1, 1'b0);
    check_eq("simul_run_count", dut_count(), 14'd7);
    check_eq("simul_run_paused", bus.running, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check_eq("simul_pause_count", dut_count(), 14'd0);
    check_eq("simul_pause_idle", bus.running, 1'b0);
    repeat (8) cyc();
    check_eq("simul_stays_idle", dut_count(), 14'd0);

    // scan at 12:34, paused
    pulse(1'b1, 1'b0, 1'b0);
    run_until(754, 4000, "to_1234");
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("scan_count", dut_count(), 14'b001_0010_011_0100);
    wait_dg(4'b1110, 1'b0, "scan_align_off");
    wait_dg(4'b1110, 1'b1, "scan_align_on");
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        check_eq("scan_dg", bus.dg, dg_exp[i]);
        check_eq("scan_seg", bus.seg, seg_exp[i]);
        check_eq("scan_dp", bus.dp, i == 2);
        cyc();
      end
    end

`ifdef CRONOMETRO_LAP_EN
    // lap snapshot at 00:05, counting continues underneath
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    run_until(5, 100, "to_0005");
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("lap_set", bus.lap_held, 1'b1);
    run_until(8, 100, "to_0008");
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("lap_live_count", dut_count(), 14'd8);
    check_eq("lap_still_held", bus.lap_held, 1'b1);
    check_display(5, "lap_disp_snap");
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("lap_release", bus.lap_held, 1'b0);
    check_display(8, "lap_disp_live");
`else
    // lap input has no effect without the lap feature
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("nolap_held", bus.lap_held, 1'b0);
    check_display(754, "nolap_disp");
`endif

    // reset in the middle of a run at 03:21
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    run_until(201, 1000, "to_0321");
    rst = 1'b1;
    cyc();
    check_eq("midrst_count", dut_count(), 14'd0);
    check_eq("midrst_running", bus.running, 1'b0);
    check_eq("midrst_dg", bus.dg, 4'b1110);
    check_eq("midrst_seg", bus.seg, 7'b1111110);
    check_eq("midrst_ovf", bus.ovf, 1'b0);
    rst = 1'b0;
    cyc();

    // randomized control traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.start_stop = ($urandom_range(15) == 0);
      bus.clear      = ($urandom_range(15) == 0);
      bus.lap        = ($urandom_range(15) == 0);
      rst            = ($urandom_range(255) == 0);
      cyc();
    end
    rst = 1'b0;
    bus.start_stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
